// File: rtl/pcie_egress.sv
// Host-bound PCIe TLP transmitter: builds a 3DW MWr/MRd header and appends the MWr payload from the local buffer.
// Latency: the first header beat is valid 1 cycle after the command is accepted; o_cmd_done pulses 1 cycle after the last beat.
// Backpressure: beats advance only on valid&ready. Payload is prefetched into a 2-entry skid, so a held-high ready gives one beat per cycle.
// Ports: clk/rst; i_enable/i_requester_id configuration; i_cmd_* command with o_cmd_rdy/o_cmd_done/o_cmd_err;
//        o_buf_re/o_buf_addr/i_buf_dat local buffer read; o_axi_egress_* / i_axi_egress_ready AXI-Stream egress.
module pcie_egress #(
    parameter int MAX_PAYLOAD_DW = 128,
    parameter int BUF_ADDR_WIDTH = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_enable,
    input  logic [15:0]               i_requester_id,
    input  logic                      i_cmd_stb,
    output logic                      o_cmd_rdy,
    input  logic                      i_cmd_wr,
    input  logic [31:0]               i_cmd_addr,
    input  logic [9:0]                i_cmd_dword_cnt,
    input  logic [7:0]                i_cmd_tag,
    input  logic [BUF_ADDR_WIDTH-1:0] i_cmd_buf_base,
    output logic                      o_cmd_done,
    output logic                      o_cmd_err,
    output logic                      o_buf_re,
    output logic [BUF_ADDR_WIDTH-1:0] o_buf_addr,
    input  logic [31:0]               i_buf_dat,
    output logic                      o_axi_egress_valid,
    output logic [31:0]               o_axi_egress_data,
    output logic [3:0]                o_axi_egress_keep,
    output logic                      o_axi_egress_last,
    input  logic                      i_axi_egress_ready
);

    localparam logic [10:0] LP_MAX = 11'(MAX_PAYLOAD_DW);

    typedef enum logic [2:0] {S_IDLE, S_HDR0, S_HDR1, S_HDR2, S_DATA} state_t;

    state_t                    r_state, w_next;
    logic                      r_wr;
    logic [31:0]               r_addr;
    logic [9:0]                r_len;
    logic [7:0]                r_tag;
    logic [15:0]               r_rid;
    logic [9:0]                r_rd_left;   // buffer reads still to issue
    logic [9:0]                r_tx_left;   // payload beats still to send
    logic [BUF_ADDR_WIDTH-1:0] r_rd_addr;
    logic                      r_pend;      // read issued last cycle, data arrives this cycle
    logic [31:0]               r_sk [2];
    logic                      r_sk_wp, r_sk_rp;
    logic [1:0]                r_sk_cnt;
    logic                      r_done, r_err;

    logic        w_accept, w_bad, w_valid, w_last, w_hs, w_pop, w_re, w_fetch;
    logic [31:0] w_data, w_dw0, w_dw1, w_dw2;
    logic [2:0]  w_occ;

    assign o_cmd_rdy = !rst && i_enable && (r_state == S_IDLE);
    assign w_accept  = i_cmd_stb && o_cmd_rdy;
    assign w_bad     = (i_cmd_dword_cnt == 10'd0) || ({1'b0, i_cmd_dword_cnt} > LP_MAX);

    assign w_dw0 = {1'b0, (r_wr ? 2'b10 : 2'b00), 5'b00000, 14'h0, r_len};
    assign w_dw1 = {r_rid, r_tag, ((r_len == 10'd1) ? 4'h0 : 4'hF), 4'hF};
    assign w_dw2 = r_addr & 32'hFFFF_FFFC;

    always_comb begin
        w_next  = r_state;
        w_valid = 1'b0;
        w_data  = 32'h0;
        w_last  = 1'b0;
        case (r_state)
            S_IDLE: if (w_accept && !w_bad) w_next = S_HDR0;
            S_HDR0: begin
                w_valid = 1'b1;
                w_data  = w_dw0;
                if (i_axi_egress_ready) w_next = S_HDR1;
            end
            S_HDR1: begin
                w_valid = 1'b1;
                w_data  = w_dw1;
                if (i_axi_egress_ready) w_next = S_HDR2;
            end
            S_HDR2: begin
                w_valid = 1'b1;
                w_data  = w_dw2;
                w_last  = !r_wr;
                if (i_axi_egress_ready) w_next = r_wr ? S_DATA : S_IDLE;
            end
            S_DATA: begin
                w_valid = (r_sk_cnt != 2'd0);
                w_data  = r_sk[r_sk_rp];
                w_last  = (r_tx_left == 10'd1);
                if (w_valid && i_axi_egress_ready && w_last) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_hs  = w_valid && i_axi_egress_ready;
    assign w_pop = (r_state == S_DATA) && w_hs;

    // Occupancy counts the in-flight read and credits this cycle's pop, so the
    // skid never overflows yet a read can be issued every cycle at full rate.
    assign w_occ   = {1'b0, r_sk_cnt} + {2'b00, r_pend} - {2'b00, w_pop};
    assign w_fetch = r_wr && (r_rd_left != 10'd0) &&
                     ((r_state == S_HDR1) || (r_state == S_HDR2) || (r_state == S_DATA));
    assign w_re    = w_fetch && (w_occ < 3'd2);

    assign o_buf_re           = w_re;
    assign o_buf_addr         = r_rd_addr;
    assign o_axi_egress_valid = w_valid;
    assign o_axi_egress_data  = w_data;
    assign o_axi_egress_last  = w_last;
    assign o_axi_egress_keep  = 4'hF;
    assign o_cmd_done         = r_done;
    assign o_cmd_err          = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_wr      <= 1'b0;
            r_addr    <= 32'h0;
            r_len     <= 10'd0;
            r_tag     <= 8'h0;
            r_rid     <= 16'h0;
            r_rd_left <= 10'd0;
            r_tx_left <= 10'd0;
            r_rd_addr <= '0;
            r_pend    <= 1'b0;
            r_sk[0]   <= 32'h0;
            r_sk[1]   <= 32'h0;
            r_sk_wp   <= 1'b0;
            r_sk_rp   <= 1'b0;
            r_sk_cnt  <= 2'd0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_hs && w_last;
            r_err   <= w_accept && w_bad;
            r_pend  <= w_re;
            if (w_accept) begin
                r_wr      <= i_cmd_wr;
                r_addr    <= i_cmd_addr;
                r_len     <= i_cmd_dword_cnt;
                r_tag     <= i_cmd_tag;
                r_rid     <= i_requester_id;
                r_rd_left <= i_cmd_wr ? i_cmd_dword_cnt : 10'd0;
                r_tx_left <= i_cmd_dword_cnt;
                r_rd_addr <= i_cmd_buf_base;
            end else if (w_re) begin
                r_rd_addr <= r_rd_addr + 1'b1;   // wraps modulo buffer size
                r_rd_left <= r_rd_left - 10'd1;
            end
            if (r_pend) begin
                r_sk[r_sk_wp] <= i_buf_dat;
                r_sk_wp       <= ~r_sk_wp;
            end
            if (w_pop) begin
                r_sk_rp   <= ~r_sk_rp;
                r_tx_left <= r_tx_left - 10'd1;
            end
            r_sk_cnt <= r_sk_cnt + 2'(r_pend) - 2'(w_pop);
        end
    end

endmodule

// File: tb/tb_pcie_egress.sv
// Directed bench for pcie_egress: header formats, payload streaming, stalls,
// command rejection, enable gating and reset in the middle of a TLP.
module tb_pcie_egress;

    logic        clk, rst, i_enable, i_cmd_stb, i_cmd_wr, i_axi_egress_ready;
    logic [15:0] i_requester_id;
    logic [31:0] i_cmd_addr, i_buf_dat;
    logic [9:0]  i_cmd_dword_cnt, i_cmd_buf_base, o_buf_addr;
    logic [7:0]  i_cmd_tag;
    logic        o_cmd_rdy, o_cmd_done, o_cmd_err, o_buf_re;
    logic        o_axi_egress_valid, o_axi_egress_last;
    logic [31:0] o_axi_egress_data;
    logic [3:0]  o_axi_egress_keep;

    pcie_egress #(.MAX_PAYLOAD_DW(128), .BUF_ADDR_WIDTH(10)) dut (
        .clk(clk), .rst(rst), .i_enable(i_enable), .i_requester_id(i_requester_id),
        .i_cmd_stb(i_cmd_stb), .o_cmd_rdy(o_cmd_rdy), .i_cmd_wr(i_cmd_wr),
        .i_cmd_addr(i_cmd_addr), .i_cmd_dword_cnt(i_cmd_dword_cnt), .i_cmd_tag(i_cmd_tag),
        .i_cmd_buf_base(i_cmd_buf_base), .o_cmd_done(o_cmd_done), .o_cmd_err(o_cmd_err),
        .o_buf_re(o_buf_re), .o_buf_addr(o_buf_addr), .i_buf_dat(i_buf_dat),
        .o_axi_egress_valid(o_axi_egress_valid), .o_axi_egress_data(o_axi_egress_data),
        .o_axi_egress_keep(o_axi_egress_keep), .o_axi_egress_last(o_axi_egress_last),
        .i_axi_egress_ready(i_axi_egress_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Local buffer model: one-cycle read latency.
    logic [31:0] mem [1024];
    logic [31:0] buf_q;
    always @(posedge clk) if (o_buf_re) buf_q <= mem[o_buf_addr];
    assign i_buf_dat = buf_q;

    int total = 0;
    int bad   = 0;

    // Captured handshakes and timing from the most recent TLP
    logic [31:0] got_d [64];
    logic        got_l [64];
    int n_hs, done_cyc, last_cyc, first_v, valid_cyc, stab_err, n_done;
    logic rdy_at0;
    logic [15:0] pat = 16'b1011_0010_1110_0101;

    task automatic send_cmd(input bit wr, input logic [31:0] addr, input logic [9:0] len,
                            input logic [7:0] tag, input logic [9:0] base);
        @(negedge clk);
        i_cmd_wr = wr; i_cmd_addr = addr; i_cmd_dword_cnt = len;
        i_cmd_tag = tag; i_cmd_buf_base = base; i_cmd_stb = 1'b1;
        @(posedge clk);
        #1 i_cmd_stb = 1'b0;
    endtask

    // Runs the egress sink for up to max_cyc cycles, recording beats and timing.
    task automatic collect(input int max_cyc, input bit toggle);
        logic prev_stall, prev_l;
        logic [31:0] prev_d;
        n_hs = 0; done_cyc = -1; last_cyc = -1; first_v = -1;
        valid_cyc = 0; stab_err = 0; n_done = 0; prev_stall = 0; prev_d = 0; prev_l = 0;
        rdy_at0 = 1'b1;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            i_axi_egress_ready = toggle ? pat[c % 16] : 1'b1;
            #1;
            if (c == 0) rdy_at0 = o_cmd_rdy;
            if (o_cmd_done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (o_axi_egress_valid) begin
                valid_cyc++;
                if (first_v < 0) first_v = c;
            end
            if (prev_stall && (!o_axi_egress_valid || o_axi_egress_data !== prev_d ||
                               o_axi_egress_last !== prev_l)) stab_err++;
            if (o_axi_egress_valid && i_axi_egress_ready && n_hs < 64) begin
                got_d[n_hs] = o_axi_egress_data;
                got_l[n_hs] = o_axi_egress_last;
                n_hs++;
                if (o_axi_egress_last) last_cyc = c;
            end
            prev_stall = o_axi_egress_valid && !i_axi_egress_ready;
            prev_d = o_axi_egress_data;
            prev_l = o_axi_egress_last;
            if (done_cyc >= 0 && c >= done_cyc + 2) break;
        end
        i_axi_egress_ready = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        total++; if (o_axi_egress_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", o_axi_egress_valid); end
        total++; if (o_axi_egress_keep !== 4'hF) begin bad++; $display("FAIL reset_keep got=%h want=f", o_axi_egress_keep); end
        total++; if ({o_cmd_rdy, o_cmd_done, o_cmd_err, o_buf_re, o_axi_egress_last} !== 5'b0)
            begin bad++; $display("FAIL reset_ctrl got=%b want=00000", {o_cmd_rdy, o_cmd_done, o_cmd_err, o_buf_re, o_axi_egress_last}); end
        total++; if (o_axi_egress_data !== 32'h0 || o_buf_addr !== 10'h0)
            begin bad++; $display("FAIL reset_data got=%h/%h want=0/0", o_axi_egress_data, o_buf_addr); end
        rst = 1'b0;
        @(negedge clk); #1;
        total++; if (o_cmd_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy_after got=%b want=1", o_cmd_rdy); end
    endtask

    task automatic test_mrd(input logic [31:0] addr, input logic [9:0] len, input logic [7:0] tag,
                            input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
        send_cmd(1'b0, addr, len, tag, 10'h0);
        collect(20, 1'b0);
        total++; if (first_v !== 0) begin bad++; $display("FAIL mrd_first_valid got=%0d want=0", first_v); end
        total++; if (rdy_at0 !== 1'b0) begin bad++; $display("FAIL mrd_rdy_drop got=%b want=0", rdy_at0); end
        total++; if (n_hs !== 3) begin bad++; $display("FAIL mrd_beats got=%0d want=3", n_hs); end
        total++; if (got_d[0] !== e0 || got_d[1] !== e1 || got_d[2] !== e2)
            begin bad++; $display("FAIL mrd_hdr got=%h %h %h want=%h %h %h", got_d[0], got_d[1], got_d[2], e0, e1, e2); end
        total++; if ({got_l[0], got_l[1], got_l[2]} !== 3'b001)
            begin bad++; $display("FAIL mrd_last got=%b want=001", {got_l[0], got_l[1], got_l[2]}); end
        total++; if (done_cyc !== last_cyc + 1 || n_done !== 1)
            begin bad++; $display("FAIL mrd_done got=cyc%0d n%0d want=cyc%0d n1", done_cyc, n_done, last_cyc + 1); end
    endtask

    task automatic test_mwr_single;
        mem[0] = 32'hDEADBEEF;
        send_cmd(1'b1, 32'h2000_0000, 10'd1, 8'h11, 10'h0);
        collect(20, 1'b0);
        total++; if (n_hs !== 4) begin bad++; $display("FAIL mwr1_beats got=%0d want=4", n_hs); end
        total++; if (got_d[0] !== 32'h4000_0001 || got_d[1] !== 32'h0100_110F ||
                     got_d[2] !== 32'h2000_0000 || got_d[3] !== 32'hDEADBEEF)
            begin bad++; $display("FAIL mwr1_dat got=%h %h %h %h want=40000001 0100110f 20000000 deadbeef",
                                  got_d[0], got_d[1], got_d[2], got_d[3]); end
        total++; if ({got_l[0], got_l[1], got_l[2], got_l[3]} !== 4'b0001)
            begin bad++; $display("FAIL mwr1_last got=%b want=0001", {got_l[0], got_l[1], got_l[2], got_l[3]}); end
        total++; if (done_cyc !== 4) begin bad++; $display("FAIL mwr1_done got=%0d want=4", done_cyc); end
    endtask

    task automatic test_mwr_burst;
        int nl;
        for (int k = 0; k < 8; k++) mem[16 + k] = 32'hA0 + 32'(k);
        send_cmd(1'b1, 32'h2000_0100, 10'd8, 8'h22, 10'h010);
        collect(30, 1'b0);
        total++; if (valid_cyc !== 11 || first_v !== 0 || last_cyc !== 10)
            begin bad++; $display("FAIL burst_timing got=v%0d f%0d l%0d want=v11 f0 l10", valid_cyc, first_v, last_cyc); end
        total++; if (got_d[0] !== 32'h4000_0008 || got_d[1] !== 32'h0100_22FF || got_d[2] !== 32'h2000_0100)
            begin bad++; $display("FAIL burst_hdr got=%h %h %h want=40000008 010022ff 20000100", got_d[0], got_d[1], got_d[2]); end
        nl = 0;
        for (int k = 0; k < 11; k++) if (got_l[k]) nl++;
        for (int k = 0; k < 8; k++) begin
            total++;
            if (got_d[3 + k] !== 32'hA0 + 32'(k))
                begin bad++; $display("FAIL burst_pay%0d got=%h want=%h", k, got_d[3 + k], 32'hA0 + 32'(k)); end
        end
        total++; if (nl !== 1 || got_l[10] !== 1'b1) begin bad++; $display("FAIL burst_last got=n%0d l10=%b want=n1 l10=1", nl, got_l[10]); end
    endtask

    task automatic test_mwr_stall;
        // Base near the top of the buffer so the read address wraps.
        for (int k = 0; k < 16; k++) mem[(1016 + k) % 1024] = 32'hA0 + 32'(k);
        i_requester_id = 16'hABCD;
        send_cmd(1'b1, 32'h4000_000B, 10'd16, 8'h33, 10'd1016);
        collect(150, 1'b1);
        i_requester_id = 16'h0100;
        total++; if (n_hs !== 19) begin bad++; $display("FAIL stall_beats got=%0d want=19", n_hs); end
        total++; if (got_d[0] !== 32'h4000_0010 || got_d[1] !== 32'hABCD_33FF || got_d[2] !== 32'h4000_0008)
            begin bad++; $display("FAIL stall_hdr got=%h %h %h want=40000010 abcd33ff 40000008", got_d[0], got_d[1], got_d[2]); end
        for (int k = 0; k < 16; k++) begin
            total++;
            if (got_d[3 + k] !== 32'hA0 + 32'(k))
                begin bad++; $display("FAIL stall_pay%0d got=%h want=%h", k, got_d[3 + k], 32'hA0 + 32'(k)); end
        end
        total++; if (stab_err !== 0) begin bad++; $display("FAIL stall_stable got=%0d want=0", stab_err); end
        total++; if (done_cyc !== last_cyc + 1 || got_l[18] !== 1'b1 || got_l[2] !== 1'b0)
            begin bad++; $display("FAIL stall_done got=d%0d l%0d want=d%0d", done_cyc, last_cyc, last_cyc + 1); end
    endtask

    task automatic test_err(input logic [9:0] len);
        int n_err, n_v, n_nrdy;
        logic err0;
        send_cmd(1'b1, 32'h5000_0000, len, 8'h44, 10'h0);
        n_err = 0; n_v = 0; n_nrdy = 0; err0 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            if (o_cmd_err) n_err++;
            if (c == 0) err0 = o_cmd_err;
            if (o_axi_egress_valid) n_v++;
            if (!o_cmd_rdy) n_nrdy++;
        end
        total++; if (err0 !== 1'b1 || n_err !== 1) begin bad++; $display("FAIL err_pulse_len%0d got=%b n%0d want=1 n1", len, err0, n_err); end
        total++; if (n_v !== 0 || n_nrdy !== 0) begin bad++; $display("FAIL err_quiet_len%0d got=v%0d nr%0d want=v0 nr0", len, n_v, n_nrdy); end
    endtask

    task automatic test_disabled;
        int n_bad;
        i_enable = 1'b0;
        @(negedge clk); #1;
        total++; if (o_cmd_rdy !== 1'b0) begin bad++; $display("FAIL dis_rdy got=%b want=0", o_cmd_rdy); end
        send_cmd(1'b0, 32'h6000_0000, 10'd0, 8'h55, 10'h0);
        n_bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            if (o_axi_egress_valid || o_cmd_err) n_bad++;
        end
        total++; if (n_bad !== 0) begin bad++; $display("FAIL dis_ignored got=%0d want=0", n_bad); end
        i_enable = 1'b1;
    endtask

    task automatic test_reset_mid;
        int n_done_seen, n_v;
        for (int k = 0; k < 8; k++) mem[32 + k] = 32'hB0 + 32'(k);
        send_cmd(1'b1, 32'h7000_0000, 10'd8, 8'h66, 10'd32);
        // Cycles 0..2 are header, 3.. payload; payload beat 3 is in cycle 6.
        for (int c = 0; c < 6; c++) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        total++; if (o_axi_egress_valid !== 1'b0 || o_cmd_done !== 1'b0)
            begin bad++; $display("FAIL rstmid_valid got=v%b d%b want=v0 d0", o_axi_egress_valid, o_cmd_done); end
        rst = 1'b0;
        n_done_seen = 0; n_v = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            if (o_cmd_done) n_done_seen++;
            if (o_axi_egress_valid) n_v++;
        end
        total++; if (n_done_seen !== 0 || n_v !== 0)
            begin bad++; $display("FAIL rstmid_quiet got=d%0d v%0d want=d0 v0", n_done_seen, n_v); end
    endtask

    initial begin
        rst = 1'b1; i_enable = 1'b1; i_requester_id = 16'h0100; i_cmd_stb = 1'b0;
        i_cmd_wr = 1'b0; i_cmd_addr = 32'h0; i_cmd_dword_cnt = 10'd0; i_cmd_tag = 8'h0;
        i_cmd_buf_base = 10'h0; i_axi_egress_ready = 1'b1;
        for (int k = 0; k < 1024; k++) mem[k] = 32'h0;
        test_reset;
        test_mrd(32'h1000_0004, 10'd4, 8'h05, 32'h0000_0004, 32'h0100_05FF, 32'h1000_0004);
        test_mwr_single;
        test_mwr_burst;
        test_mwr_stall;
        test_err(10'd0);
        test_err(10'd129);
        test_mrd(32'h1234_5678, 10'd128, 8'h77, 32'h0000_0080, 32'h0100_77FF, 32'h1234_5678);
        test_disabled;
        test_reset_mid;
        test_mrd(32'h3000_00FC, 10'd2, 8'hA5, 32'h0000_0002, 32'h0100_A5FF, 32'h3000_00FC);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
